cmplx_sqrt_dispatcher: RTL and testbench
========================================

# cmplx_sqrt_dispatcher

Buffers a stream of complex Q1.15 samples and feeds the complex square-root core one sample at a time. It generates the core's single-cycle `start` pulse, waits for `cmplx_sqrt_valid` and captures the result. The result is presented on a ready/valid output port. It sits directly upstream of `Top_Complex_SquareRoot`, in place of a bench or host that hand-pulses `start`.

## Interface
- `DEPTH`, 8: input FIFO depth, power of 2, ≥2.
- `ITER_N`, 16: iteration count driven on `core_N`.
- `TIMEOUT`, 127: watchdog limit in cycles; used only when `CSQ_DISPATCH_TIMEOUT_EN` is defined.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: FIFO can accept a sample.
- `in_re`, `in_im` in 16 each: sample, Q1.15 signed.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_re`, `out_im` out 16 each: square-root result.
- `out_err` out 1: result was produced by the timeout path.
- `core_start` out 1: to core `start`.
- `core_N` out 8: to core `N`.
- `core_x`, `core_y` out 16 each: to core `x_in` and `y_in`.
- `core_real`, `core_img` in 16 each: from core `cmplx_sqrt_real_out` and `cmplx_sqrt_img_out`.
- `core_valid` in 1: from core `cmplx_sqrt_valid`.
- `busy` out 1: FSM is not in IDLE, or the FIFO is non-empty.
- `fifo_level` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
**FIFO**
- Circular buffer with wr_ptr, rd_ptr and count.
- Push when `in_valid && in_ready`.
- `in_ready = !rst && (count != DEPTH)`. When full, `in_valid` is ignored and no data is dropped or overwritten.
- Pointers wrap modulo DEPTH.
- No bypass: a sample is issued only from a stored entry.
- Push and pop in the same cycle leave count unchanged.

**FSM states: IDLE, WAIT, HOLD**
- IDLE, with count>0:
  - register the FIFO head into `core_x` and `core_y`;
  - pop the FIFO;
  - `core_start <= 1` for exactly one cycle;
  - go to WAIT.
- WAIT, on `core_valid`:
  - `out_re <= core_real`, `out_im <= core_img`, `out_err <= 0`;
  - `out_valid <= 1`;
  - go to HOLD.
- HOLD:
  - `out_re`, `out_im`, `out_err` and `out_valid` stay stable until `out_valid && out_ready`;
  - on that handshake, `out_valid <= 0` and go to IDLE.
- `core_valid` is ignored in IDLE and HOLD.
- `core_x` and `core_y` hold their value until the next issue.
- `core_N` is constant at ITER_N after reset.
- Exactly one sample is in flight in the core at any time.
- Sample order is preserved.

**Reset**
- Clears count and both pointers; the FSM goes to IDLE.
- Output values during and after reset: `out_valid`=0, `out_re`=0, `out_im`=0, `out_err`=0, `core_start`=0, `core_x`=0, `core_y`=0, `busy`=0, `fifo_level`=0.
- `core_N` is 0 while `rst` is high and ITER_N from the first cycle after reset.
- Reset mid-operation flushes the FIFO and abandons any in-flight result. A later `core_valid` arrives in IDLE and is ignored.

## Timing
- Sample pushed at edge k into an empty FIFO with the FSM in IDLE:
  - `fifo_level`=1 after edge k;
  - `core_start`=1 after edge k+1 and 0 after edge k+2.
- `core_valid` sampled high at edge m: `out_valid`=1 after edge m.
- HOLD handshake at edge h: state is IDLE after h. If the FIFO is non-empty, the next `core_start` is high after edge h+1.
- Minimum spacing between `core_start` pulses is one result latency plus 2 cycles.
- `in_ready` depends on registered count only; there is no combinational path from `out_ready`.

## Configuration
**`CSQ_DISPATCH_TIMEOUT_EN`**
- Defined:
  - an 8-bit counter clears on issue and increments each cycle in WAIT;
  - when it reaches TIMEOUT without `core_valid`, the block sets `out_re`=0, `out_im`=0, `out_err`=1, `out_valid`=1 and goes to HOLD;
  - `core_valid` in the timeout cycle itself takes priority, giving a normal result.
- Undefined:
  - no counter;
  - WAIT lasts indefinitely;
  - `out_err` is constant 0.

## Test plan
- **Single sample.** Reset, then push (0x6000, 0x370A). The core BFM returns (0x7302, 0x1EA2) 20 cycles after `core_start`. Required:
  - `core_x`=0x6000 and `core_y`=0x370A while `core_start` pulses one cycle, 1 cycle after the push;
  - `core_N`=16;
  - `out_re`=0x7302, `out_im`=0x1EA2, `out_err`=0.
- **Fill and order.** Push 9 samples back-to-back with DEPTH=8 while the core is stalled. Required:
  - `in_ready` drops when `fifo_level`=8;
  - no sample is lost;
  - results emerge in push order.
- **Output backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`. Required:
  - outputs remain stable;
  - no new `core_start` is issued;
  - spurious `core_valid` pulses are ignored.
- **Reset mid-WAIT.** Assert `rst` with 3 samples queued, then the BFM fires `core_valid`. Required:
  - `fifo_level`=0;
  - `out_valid` stays 0;
  - no `core_start` is issued.
- **Timeout** (macro defined, TIMEOUT=127). The BFM never responds. Required:
  - `out_valid`=1 with `out_err`=1 and (0, 0), 127 cycles after `core_start`;
  - the next queued sample is issued after the handshake.
- **Simultaneous push and pop.** Push at the same edge as the IDLE pop with count=1. Required:
  - `fifo_level` stays 1;
  - the pushed value becomes the next issue.

Source files
------------

// File: rtl/cmplx_sqrt_dispatcher.sv
// Buffers Q1.15 complex samples and hands them one at a time to the complex square-root core.
// Define CSQ_DISPATCH_TIMEOUT_EN to add a watchdog that turns a stalled core into an error result.
module cmplx_sqrt_dispatcher #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ITER_N  = 16,
    parameter int unsigned TIMEOUT = 127
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_re,
    input  logic [15:0]              in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_re,
    output logic [15:0]              out_im,
    output logic                     out_err,
    output logic                     core_start,
    output logic [7:0]               core_N,
    output logic [15:0]              core_x,
    output logic [15:0]              core_y,
    input  logic [15:0]              core_real,
    input  logic [15:0]              core_img,
    input  logic                     core_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } sample_t;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

    state_t        state;
    state_t        state_next;
    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          issue;
    logic          capture;
    logic          release_out;
`ifdef CSQ_DISPATCH_TIMEOUT_EN
    logic [7:0]    tmo_cnt;
    logic          tmo_hit;
    logic          err_q;
`endif

    // The watchdog counter is 8 bits wide; the FIFO pointers rely on natural wrap.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..255");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    assign in_ready   = !rst && (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_level = count;
    assign busy       = (state != IDLE) || (count != '0);

    // Next-state and single-cycle control decode.
    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
`ifdef CSQ_DISPATCH_TIMEOUT_EN
        tmo_hit     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (core_valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
`ifdef CSQ_DISPATCH_TIMEOUT_EN
                else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    state_next = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_re, in_im};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_start <= 1'b0;
            core_N     <= '0;
            core_x     <= '0;
            core_y     <= '0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            core_start <= issue;
            core_N     <= 8'(ITER_N);
            if (issue) begin
                core_x <= mem[rd_ptr].re;
                core_y <= mem[rd_ptr].im;
            end
            if (capture) begin
                out_re    <= core_real;
                out_im    <= core_img;
                out_valid <= 1'b1;
            end
`ifdef CSQ_DISPATCH_TIMEOUT_EN
            else if (tmo_hit) begin
                out_re    <= '0;
                out_im    <= '0;
                out_valid <= 1'b1;
            end
`endif
            else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CSQ_DISPATCH_TIMEOUT_EN
    // Watchdog: cycles spent waiting on the current issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (issue) tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 8'd1;
            if (capture) err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmplx_sqrt_dispatcher.sv
// Self-checking bench for cmplx_sqrt_dispatcher with a stand-in core BFM and a queue-based model.
module tb_cmplx_sqrt_dispatcher;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   in_re = '0;
    logic [15:0]   in_im = '0;
    logic          in_ready, out_valid, out_err, core_start, busy;
    logic [15:0]   out_re, out_im, core_x, core_y;
    logic [7:0]    core_N;
    logic [LW-1:0] fifo_level;

    logic          bfm_valid = 1'b0;
    logic          spur_valid = 1'b0;
    logic [15:0]   bfm_re = '0, bfm_im = '0, spur_re = '0, spur_im = '0;
    logic          core_valid;
    logic [15:0]   core_real, core_img;
    assign core_valid = bfm_valid | spur_valid;
    assign core_real  = bfm_valid ? bfm_re : spur_re;
    assign core_img   = bfm_valid ? bfm_im : spur_im;

    bit  bfm_en = 1'b1;
    bit  bfm_stall = 1'b0;
    bit  bfm_rand = 1'b0;
    int  bfm_lat = 20;
    int  checks = 0;
    int  errors = 0;
    int  start_cnt = 0;
    int  start_double = 0;
    logic start_prev = 1'b0;
    logic [15:0] q_re[$];
    logic [15:0] q_im[$];

    cmplx_sqrt_dispatcher #(.DEPTH(DEPTH), .ITER_N(16), .TIMEOUT(127)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_err(out_err), .core_start(core_start), .core_N(core_N),
        .core_x(core_x), .core_y(core_y), .core_real(core_real), .core_img(core_img),
        .core_valid(core_valid), .busy(busy), .fifo_level(fifo_level)
    );

    initial forever #5 clk = ~clk;

    // Stand-in for the square-root core: a fixed bijection of the operands.
    function automatic logic [15:0] ref_re(input logic [15:0] x);
        return x ^ 16'h1302;
    endfunction
    function automatic logic [15:0] ref_im(input logic [15:0] y);
        return y ^ 16'h29A8;
    endfunction

    always @(posedge clk) begin
        if (core_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            if (start_prev) start_double <= start_double + 1;
        end
        start_prev <= (core_start === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core BFM: answers each start after a latency, optionally stalled or disabled.
    initial begin
        logic [15:0] bx, by;
        int lat;
        forever begin
            step();
            if (core_start === 1'b1 && bfm_en) begin
                bx = core_x;
                by = core_y;
                lat = bfm_rand ? int'($urandom_range(1, 8)) : bfm_lat;
                while (bfm_stall) step();
                repeat (lat - 1) step();
                bfm_re = ref_re(bx);
                bfm_im = ref_im(by);
                bfm_valid = 1'b1;
                step();
                bfm_valid = 1'b0;
            end
        end
    end

    task automatic push(input logic [15:0] re, input logic [15:0] im, output bit acc);
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        acc = in_ready;
        step();
        in_valid = 1'b0;
        if (acc) begin
            q_re.push_back(re);
            q_im.push_back(im);
        end
    endtask

    task automatic model_pop(output logic [15:0] er, output logic [15:0] ei, output bit ok);
        ok = (q_re.size() != 0);
        er = '0;
        ei = '0;
        if (ok) begin
            er = ref_re(q_re.pop_front());
            ei = ref_im(q_im.pop_front());
        end
    endtask

    task automatic wait_out(input int budget, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({out_valid, out_re, out_im, out_err, core_start, core_x, core_y, busy, fifo_level, core_N, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b re=%h im=%h err=%b st=%b x=%h y=%h busy=%b lvl=%0d N=%0d rdy=%b, expected all zero",
                     out_valid, out_re, out_im, out_err, core_start, core_x, core_y, busy, fifo_level, core_N, in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (core_N !== 8'd16 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got N=%0d in_ready=%b, expected N=16 in_ready=1", core_N, in_ready);
        end
    endtask

    task automatic test_single();
        bit acc;
        int n;
        logic [15:0] er, ei;
        bit ok;
        bfm_lat = 20;
        push(16'h6000, 16'h370A, acc);
        checks++;
        if (fifo_level !== LW'(1) || core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got lvl=%0d start=%b, expected lvl=1 start=0", fifo_level, core_start);
        end
        step();
        checks++;
        if (core_start !== 1'b1 || core_x !== 16'h6000 || core_y !== 16'h370A || core_N !== 8'd16) begin
            errors++;
            $display("FAIL single_issue: got start=%b x=%h y=%h N=%0d, expected 1 6000 370a 16", core_start, core_x, core_y, core_N);
        end
        step();
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got start=%b, expected 0", core_start);
        end
        wait_out(60, n);
        checks++;
        if (n !== 19) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, expected 19", n);
        end
        model_pop(er, ei, ok);
        checks++;
        if (out_re !== 16'h7302 || out_im !== 16'h1EA2 || out_err !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL single_result: got re=%h im=%h err=%b, expected 7302 1ea2 0", out_re, out_im, out_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got v=%b busy=%b, expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_fill();
        bit acc;
        int accepted = 0;
        int n;
        logic [15:0] er, ei;
        bit ok;
        bfm_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(16'($urandom), 16'($urandom), acc);
            if (acc) accepted++;
            checks++;
            if (in_ready !== (fifo_level != LW'(DEPTH))) begin
                errors++;
                $display("FAIL fill_ready: got in_ready=%b at lvl=%0d, expected %b", in_ready, fifo_level, fifo_level != LW'(DEPTH));
            end
        end
        checks++;
        if (accepted !== 9 || fifo_level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL fill_count: got accepted=%0d lvl=%0d, expected 9 8", accepted, fifo_level);
        end
        bfm_stall = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_out(60, n);
            model_pop(er, ei, ok);
            checks++;
            if (out_valid !== 1'b1 || !ok || out_re !== er || out_im !== ei || out_err !== 1'b0) begin
                errors++;
                $display("FAIL fill_order[%0d]: got v=%b re=%h im=%h, expected 1 %h %h", i, out_valid, out_re, out_im, er, ei);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit acc;
        int n;
        int sc;
        logic [15:0] er, ei;
        bit ok;
        push(16'($urandom), 16'($urandom), acc);
        push(16'($urandom), 16'($urandom), acc);
        wait_out(60, n);
        model_pop(er, ei, ok);
        sc = start_cnt;
        for (int i = 0; i < 10; i++) begin
            spur_valid = 1'($urandom_range(0, 1));
            spur_re = 16'($urandom);
            spur_im = 16'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || !ok || out_re !== er || out_im !== ei || out_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b re=%h im=%h, expected 1 %h %h", i, out_valid, out_re, out_im, er, ei);
            end
        end
        spur_valid = 1'b0;
        checks++;
        if (start_cnt !== sc || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL hold_no_issue: got starts=%0d lvl=%0d, expected %0d 1", start_cnt, fifo_level, sc);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got v=%b start=%b, expected 0 0", out_valid, core_start);
        end
        step();
        checks++;
        if (core_start !== 1'b1 || q_re.size() == 0 || core_x !== q_re[0]) begin
            errors++;
            $display("FAIL hold_next_issue: got start=%b x=%h, expected 1 and queued head", core_start, core_x);
        end
        wait_out(60, n);
        model_pop(er, ei, ok);
        checks++;
        if (out_valid !== 1'b1 || !ok || out_re !== er || out_im !== ei) begin
            errors++;
            $display("FAIL hold_second: got v=%b re=%h im=%h, expected 1 %h %h", out_valid, out_re, out_im, er, ei);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        bit acc;
        int n;
        logic [15:0] ax, bx, er, ei;
        bit ok;
        ax = 16'($urandom);
        bx = 16'($urandom);
        push(ax, 16'($urandom), acc);
        push(bx, 16'($urandom), acc);
        checks++;
        if (fifo_level !== LW'(1) || core_start !== 1'b1 || core_x !== ax) begin
            errors++;
            $display("FAIL simul_level: got lvl=%0d start=%b x=%h, expected 1 1 %h", fifo_level, core_start, core_x, ax);
        end
        out_ready = 1'b1;
        wait_out(60, n);
        model_pop(er, ei, ok);
        checks++;
        if (out_valid !== 1'b1 || !ok || out_re !== er || out_im !== ei) begin
            errors++;
            $display("FAIL simul_first: got v=%b re=%h im=%h, expected 1 %h %h", out_valid, out_re, out_im, er, ei);
        end
        step();
        n = 0;
        while (core_start !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (core_start !== 1'b1 || core_x !== bx) begin
            errors++;
            $display("FAIL simul_next_issue: got start=%b x=%h, expected 1 %h", core_start, core_x, bx);
        end
        wait_out(60, n);
        model_pop(er, ei, ok);
        checks++;
        if (out_valid !== 1'b1 || !ok || out_re !== er || out_im !== ei) begin
            errors++;
            $display("FAIL simul_second: got v=%b re=%h im=%h, expected 1 %h %h", out_valid, out_re, out_im, er, ei);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bit acc;
        int n;
        logic [15:0] er, ei, sr, si;
        bit ok;
        bfm_en = 1'b0;
        push(16'($urandom), 16'($urandom), acc);
        push(16'($urandom), 16'($urandom), acc);
        checks++;
        if (core_start !== 1'b1 || core_x !== q_re[0]) begin
            errors++;
            $display("FAIL stall_issue: got start=%b x=%h, expected 1 %h", core_start, core_x, q_re[0]);
        end
`ifdef CSQ_DISPATCH_TIMEOUT_EN
        wait_out(300, n);
        model_pop(er, ei, ok);
        checks++;
        if (n !== 127 || out_valid !== 1'b1 || out_err !== 1'b1 || out_re !== 16'h0 || out_im !== 16'h0) begin
            errors++;
            $display("FAIL timeout_result: got n=%0d v=%b err=%b re=%h im=%h, expected 127 1 1 0 0", n, out_valid, out_err, out_re, out_im);
        end
`else
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (out_valid !== 1'b0) n++;
        end
        checks++;
        if (n !== 0 || busy !== 1'b1 || out_err !== 1'b0 || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL wait_forever: got early=%0d busy=%b err=%b lvl=%0d, expected 0 1 0 1", n, busy, out_err, fifo_level);
        end
        model_pop(er, ei, ok);
        sr = 16'($urandom);
        si = 16'($urandom);
        spur_re = sr;
        spur_im = si;
        spur_valid = 1'b1;
        step();
        spur_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_re !== sr || out_im !== si || out_err !== 1'b0) begin
            errors++;
            $display("FAIL late_result: got v=%b re=%h im=%h err=%b, expected 1 %h %h 0", out_valid, out_re, out_im, out_err, sr, si);
        end
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        checks++;
        if (core_start !== 1'b1 || q_re.size() == 0 || core_x !== q_re[0]) begin
            errors++;
            $display("FAIL stall_next_issue: got start=%b x=%h, expected 1 and queued head", core_start, core_x);
        end
`ifdef CSQ_DISPATCH_TIMEOUT_EN
        wait_out(300, n);
        checks++;
        if (n !== 127 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_second: got n=%0d err=%b, expected 127 1", n, out_err);
        end
`else
        repeat (5) step();
        sr = 16'($urandom);
        spur_re = sr;
        spur_im = 16'h0;
        spur_valid = 1'b1;
        step();
        spur_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_re !== sr || out_err !== 1'b0) begin
            errors++;
            $display("FAIL late_second: got v=%b re=%h err=%b, expected 1 %h 0", out_valid, out_re, out_err, sr);
        end
`endif
        model_pop(er, ei, ok);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        bfm_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        bit acc;
        int sc;
        int bad = 0;
        bfm_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(16'($urandom), 16'($urandom), acc);
        checks++;
        if (fifo_level !== LW'(3) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got lvl=%0d busy=%b, expected 3 1", fifo_level, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready: got %b, expected 0", in_ready);
        end
        step();
        step();
        rst = 1'b0;
        q_re.delete();
        q_im.delete();
        sc = start_cnt;
        bfm_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0 || fifo_level !== LW'(0) || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || start_cnt !== sc) begin
            errors++;
            $display("FAIL rst_mid_flush: got bad_cycles=%0d starts=%0d, expected 0 %0d", bad, start_cnt, sc);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit hs;
        logic [15:0] er, ei;
        bit ok;
        int n = 0;
        bfm_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (hs) begin
                model_pop(er, ei, ok);
                checks++;
                if (!ok || out_re !== er || out_im !== ei || out_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got re=%h im=%h err=%b, expected %h %h 0", i, out_re, out_im, out_err, er, ei);
                end
            end
            if (acc) begin
                q_re.push_back(in_re);
                q_im.push_back(in_im);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q_re.size() != 0 && n < 3000) begin
            if (out_valid === 1'b1) begin
                model_pop(er, ei, ok);
                checks++;
                if (out_re !== er || out_im !== ei || out_err !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_result: got re=%h im=%h, expected %h %h", out_re, out_im, er, ei);
                end
            end
            step();
            n++;
        end
        step();
        out_ready = 1'b0;
        bfm_rand = 1'b0;
        checks++;
        if (q_re.size() != 0 || busy !== 1'b0 || start_double !== 0) begin
            errors++;
            $display("FAIL drain_done: got left=%0d busy=%b wide_starts=%0d, expected 0 0 0", q_re.size(), busy, start_double);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_simul_push_pop();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
